hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter MDU_LAT, default 4, SHALL be the number of cycles a mul/div op occupies EX; legal range 1..15.
REQ-002 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 ID_RegRs  input  5  Rs field of the instruction in ID.
REQ-005 ID_RegRt  input  5  Rt field of the instruction in ID.
REQ-006 ID_UsesRt  input  1  ID instruction reads Rt as a source.
REQ-007 ID_MduOp  input  1  ID instruction is mul/div.
REQ-008 EX_MemRead  input  1  EX instruction is a load.
REQ-009 EX_RegRt  input  5  destination of the EX load.
REQ-010 EX_BranchTaken  input  1  branch resolved taken in EX this cycle.
REQ-011 PC_Write  output  1  PC load enable.
REQ-012 IFID_Write  output  1  IF/ID register enable.
REQ-013 IFID_Flush  output  1  clear IF/ID to NOP.
REQ-014 IDEX_Write  output  1  ID/EX register enable.
REQ-015 IDEX_Bubble  output  1  load NOP into ID/EX.
REQ-016 EXMEM_Bubble  output  1  load NOP into EX/MEM.
REQ-017 MDU_Busy  output  1  mul/div occupying EX beyond its first cycle.
REQ-018 Stall_Cnt  output  16  saturating count of cycles with PC_Write=0.

Function
REQ-019 The FSM SHALL have two states: RUN and MDU_WAIT; a 4-bit down-counter mdu_cnt SHALL be kept.
REQ-020 load_use SHALL be EX_MemRead && EX_RegRt!=0 && (EX_RegRt==ID_RegRs || (ID_UsesRt && EX_RegRt==ID_RegRt)).
REQ-021 Outputs SHALL be combinational from state, mdu_cnt and inputs (zero latency); defaults: PC_Write=IFID_Write=IDEX_Write=1, all flush/bubble=0, MDU_Busy=0.
REQ-022 RUN priority SHALL be EX_BranchTaken > load_use > ID_MduOp.
REQ-023 RUN, EX_BranchTaken=1: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; next state RUN; ID_MduOp and load_use ignored.
REQ-024 RUN, load_use=1: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next state RUN.
REQ-025 RUN, ID_MduOp=1, no branch or load_use, MDU_LAT>1: defaults apply (op enters EX); next state MDU_WAIT, mdu_cnt<=MDU_LAT-1.
REQ-026 MDU_LAT==1: ID_MduOp SHALL not leave RUN.
REQ-027 MDU_WAIT: PC_Write=IFID_Write=IDEX_Write=0, EXMEM_Bubble=1, MDU_Busy=1; mdu_cnt decrements each cycle; when mdu_cnt==1, next state RUN.
REQ-028 MDU_WAIT SHALL last exactly MDU_LAT-1 cycles; total EX occupancy MDU_LAT cycles.
REQ-029 EX_BranchTaken, EX_MemRead, ID_MduOp SHALL be ignored in MDU_WAIT.
REQ-030 Stall_Cnt SHALL increment by 1 on every edge where rst_i=1 and PC_Write=0, saturating at 16'hFFFF.

Reset
REQ-031 Edge with rst_i=0: state<=RUN, mdu_cnt<=0, Stall_Cnt<=0, including when in MDU_WAIT.
REQ-032 While rst_i=0: PC_Write=IFID_Write=IDEX_Write=0, IFID_Flush=IDEX_Bubble=EXMEM_Bubble=1, MDU_Busy=0.
REQ-033 First cycle after release SHALL use RUN defaults.

Verification
REQ-034 EX_MemRead=1, EX_RegRt=8, ID_RegRs=8 -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1 that cycle; Stall_Cnt +1.
REQ-035 Same with EX_RegRt=0, or ID_RegRt=8 with ID_UsesRt=0 -> no stall, defaults.
REQ-036 EX_BranchTaken=1 with load_use=1 and ID_MduOp=1 -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; next cycle RUN.
REQ-037 MDU_LAT=4, ID_MduOp=1 in RUN -> MDU_Busy=1, EXMEM_Bubble=1, PC_Write=0 for exactly 3 cycles, then RUN; Stall_Cnt +3.
REQ-038 rst_i=0 in second MDU_WAIT cycle -> next cycle RUN, MDU_Busy=0, Stall_Cnt=0.
REQ-039 Force 65 536 stall cycles -> Stall_Cnt holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bundle: ID/EX hazard sources in, stage enables and
// bubble/flush controls out. The sequencer sits on the slave side.
interface hazard_sequencer_if;
   logic [4:0]  ID_RegRs;
   logic [4:0]  ID_RegRt;
   logic        ID_UsesRt;
   logic        ID_MduOp;
   logic        EX_MemRead;
   logic [4:0]  EX_RegRt;
   logic        EX_BranchTaken;
   logic        PC_Write;
   logic        IFID_Write;
   logic        IFID_Flush;
   logic        IDEX_Write;
   logic        IDEX_Bubble;
   logic        EXMEM_Bubble;
   logic        MDU_Busy;
   logic [15:0] Stall_Cnt;

   modport master (
      output ID_RegRs, ID_RegRt, ID_UsesRt, ID_MduOp,
             EX_MemRead, EX_RegRt, EX_BranchTaken,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
             IDEX_Bubble, EXMEM_Bubble, MDU_Busy, Stall_Cnt
   );

   modport slave (
      input  ID_RegRs, ID_RegRt, ID_UsesRt, ID_MduOp,
             EX_MemRead, EX_RegRt, EX_BranchTaken,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Write,
             IDEX_Bubble, EXMEM_Bubble, MDU_Busy, Stall_Cnt
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: resolves taken branches, load-use hazards and multi-cycle
// mul/div occupancy of EX into stage enable / bubble / flush controls, and
// counts cycles in which the PC is held.
module hazard_sequencer #(
   parameter int unsigned MDU_LAT = 4   // cycles a mul/div op occupies EX, 1..15
) (
   input logic             clk_i,
   input logic             rst_i,   // synchronous, active-low
   hazard_sequencer_if.slave hz
);

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] MDU_CNT_LOAD = 4'(MDU_LAT - 1);

   state_t      state, stateNext;
   logic [3:0]  mduCnt, mduCntNext;
   logic [15:0] stallCnt;
   logic        loadUse;

   logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemBubble, mduBusy;

   // Load in EX whose destination feeds a source of the ID instruction.
   always_comb begin
      loadUse = hz.EX_MemRead && (hz.EX_RegRt != 5'd0) &&
                ((hz.EX_RegRt == hz.ID_RegRs) ||
                 (hz.ID_UsesRt && (hz.EX_RegRt == hz.ID_RegRt)));
   end

   // Next-state and zero-latency control outputs.
   always_comb begin
      stateNext   = state;
      mduCntNext  = mduCnt;
      pcWrite     = 1'b1;
      ifidWrite   = 1'b1;
      ifidFlush   = 1'b0;
      idexWrite   = 1'b1;
      idexBubble  = 1'b0;
      exmemBubble = 1'b0;
      mduBusy     = 1'b0;

      if (!rst_i) begin
         pcWrite     = 1'b0;
         ifidWrite   = 1'b0;
         idexWrite   = 1'b0;
         ifidFlush   = 1'b1;
         idexBubble  = 1'b1;
         exmemBubble = 1'b1;
         stateNext   = RUN;
         mduCntNext  = '0;
      end else begin
         case (state)
            RUN: begin
               if (hz.EX_BranchTaken) begin
                  ifidFlush  = 1'b1;
                  idexBubble = 1'b1;
               end else if (loadUse) begin
                  pcWrite    = 1'b0;
                  ifidWrite  = 1'b0;
                  idexBubble = 1'b1;
               end else if (hz.ID_MduOp && (MDU_LAT > 1)) begin
                  // op enters EX this cycle; hold the front end for the rest
                  stateNext  = MDU_WAIT;
                  mduCntNext = MDU_CNT_LOAD;
               end
            end
            MDU_WAIT: begin
               pcWrite     = 1'b0;
               ifidWrite   = 1'b0;
               idexWrite   = 1'b0;
               exmemBubble = 1'b1;
               mduBusy     = 1'b1;
               mduCntNext  = mduCnt - 4'd1;
               if (mduCnt == 4'd1) stateNext = RUN;
            end
            default: stateNext = RUN;
         endcase
      end
   end

   // State and occupancy counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state  <= RUN;
         mduCnt <= '0;
      end else begin
         state  <= stateNext;
         mduCnt <= mduCntNext;
      end
   end

   // Saturating count of cycles with the PC held.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stallCnt <= '0;
      end else if (!pcWrite && (stallCnt != 16'hFFFF)) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   assign hz.PC_Write     = pcWrite;
   assign hz.IFID_Write   = ifidWrite;
   assign hz.IFID_Flush   = ifidFlush;
   assign hz.IDEX_Write   = idexWrite;
   assign hz.IDEX_Bubble  = idexBubble;
   assign hz.EXMEM_Bubble = exmemBubble;
   assign hz.MDU_Busy     = mduBusy;
   assign hz.Stall_Cnt    = stallCnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MDU_LAT = 4).
// Control outputs are observed as a 7-bit vector:
// {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MDU_Busy}
module tb_hazard_sequencer;

   localparam logic [6:0] O_RUN  = 7'b1101000;
   localparam logic [6:0] O_RST  = 7'b0010110;
   localparam logic [6:0] O_LU   = 7'b0001100;
   localparam logic [6:0] O_BR   = 7'b1111100;
   localparam logic [6:0] O_WAIT = 7'b0000011;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   hazard_sequencer_if bus ();

   hazard_sequencer #(.MDU_LAT(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {bus.PC_Write, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Write,
              bus.IDEX_Bubble, bus.EXMEM_Bubble, bus.MDU_Busy};
   endfunction

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                        input logic mdu, input logic memRd, input logic [4:0] exRt,
                        input logic br);
      bus.ID_RegRs       = rs;
      bus.ID_RegRt       = rt;
      bus.ID_UsesRt      = usesRt;
      bus.ID_MduOp       = mdu;
      bus.EX_MemRead     = memRd;
      bus.EX_RegRt       = exRt;
      bus.EX_BranchTaken = br;
      #1;
   endtask

   task automatic test_reset();
      cyc();
      rst = 1'b0;
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RST) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), O_RST); end
      total++;
      if (bus.Stall_Cnt !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", bus.Stall_Cnt); end
      cyc();
      rst = 1'b1;
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL release_outs got=%b exp=%b", outs(), O_RUN); end
   endtask

   task automatic test_load_use();
      cyc();
      setIn(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
      total++;
      if (outs() !== O_LU) begin bad++; $display("FAIL lu_rs got=%b exp=%b", outs(), O_LU); end
      cyc();
      total++;
      if (bus.Stall_Cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=1", bus.Stall_Cnt); end
      setIn(5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
      total++;
      if (outs() !== O_LU) begin bad++; $display("FAIL lu_rt got=%b exp=%b", outs(), O_LU); end
      cyc();
      total++;
      if (bus.Stall_Cnt !== 16'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=2", bus.Stall_Cnt); end
   endtask

   task automatic test_no_stall();
      setIn(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL ns_r0 got=%b exp=%b", outs(), O_RUN); end
      cyc();
      setIn(5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL ns_nouse got=%b exp=%b", outs(), O_RUN); end
      cyc();
      setIn(5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL ns_noload got=%b exp=%b", outs(), O_RUN); end
      cyc();
      total++;
      if (bus.Stall_Cnt !== 16'd2) begin bad++; $display("FAIL ns_cnt got=%0d exp=2", bus.Stall_Cnt); end
   endtask

   task automatic test_branch_priority();
      setIn(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
      total++;
      if (outs() !== O_BR) begin bad++; $display("FAIL br_prio got=%b exp=%b", outs(), O_BR); end
      cyc();
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL br_next got=%b exp=%b", outs(), O_RUN); end
      total++;
      if (bus.Stall_Cnt !== 16'd2) begin bad++; $display("FAIL br_cnt got=%0d exp=2", bus.Stall_Cnt); end
   endtask

   task automatic test_mdu();
      cyc();
      setIn(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL mdu_issue got=%b exp=%b", outs(), O_RUN); end
      for (int i = 0; i < 3; i++) begin
         cyc();
         // branch, load-use and another mul/div must all be ignored while waiting
         setIn(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, (i == 1));
         total++;
         if (outs() !== O_WAIT) begin bad++; $display("FAIL mdu_wait%0d got=%b exp=%b", i, outs(), O_WAIT); end
      end
      cyc();
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL mdu_done got=%b exp=%b", outs(), O_RUN); end
      total++;
      if (bus.Stall_Cnt !== 16'd5) begin bad++; $display("FAIL mdu_cnt got=%0d exp=5", bus.Stall_Cnt); end
   endtask

   task automatic test_mdu_reset();
      cyc();
      setIn(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      cyc();
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_WAIT) begin bad++; $display("FAIL mr_wait1 got=%b exp=%b", outs(), O_WAIT); end
      cyc();
      total++;
      if (bus.Stall_Cnt !== 16'd6) begin bad++; $display("FAIL mr_cnt6 got=%0d exp=6", bus.Stall_Cnt); end
      rst = 1'b0;
      #1;
      total++;
      if (outs() !== O_RST) begin bad++; $display("FAIL mr_rstouts got=%b exp=%b", outs(), O_RST); end
      cyc();
      rst = 1'b1;
      #1;
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL mr_after got=%b exp=%b", outs(), O_RUN); end
      total++;
      if (bus.Stall_Cnt !== 16'd0) begin bad++; $display("FAIL mr_cnt0 got=%0d exp=0", bus.Stall_Cnt); end
   endtask

   task automatic test_back_to_back();
      // mul/div held in ID: issue, 3 wait cycles, issue again, wait again
      cyc();
      setIn(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL b2b_issue1 got=%b exp=%b", outs(), O_RUN); end
      for (int i = 0; i < 3; i++) cyc();
      total++;
      if (outs() !== O_WAIT) begin bad++; $display("FAIL b2b_wait3 got=%b exp=%b", outs(), O_WAIT); end
      cyc();
      total++;
      if (outs() !== O_RUN) begin bad++; $display("FAIL b2b_issue2 got=%b exp=%b", outs(), O_RUN); end
      cyc();
      total++;
      if (outs() !== O_WAIT) begin bad++; $display("FAIL b2b_wait_again got=%b exp=%b", outs(), O_WAIT); end
      total++;
      if (bus.Stall_Cnt !== 16'd3) begin bad++; $display("FAIL b2b_cnt got=%0d exp=3", bus.Stall_Cnt); end
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_saturation();
      cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      setIn(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
      for (int i = 0; i < 65534; i++) cyc();
      total++;
      if (bus.Stall_Cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h exp=fffe", bus.Stall_Cnt); end
      cyc();
      total++;
      if (bus.Stall_Cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h exp=ffff", bus.Stall_Cnt); end
      for (int i = 0; i < 4; i++) cyc();
      total++;
      if (bus.Stall_Cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", bus.Stall_Cnt); end
      total++;
      if (outs() !== O_LU) begin bad++; $display("FAIL sat_outs got=%b exp=%b", outs(), O_LU); end
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch_priority();
      test_mdu();
      test_mdu_reset();
      test_back_to_back();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
